// File: rtl/culsans_wr_arbiter.sv
// culsans_wr_arbiter: round-robin AW arbiter with an index FIFO that steers W bursts in AW order
module culsans_wr_arbiter #(
  parameter int NumReq   = 2,
  parameter int AwWidth  = 85,
  parameter int WWidth   = 74,
  parameter int OrdDepth = 4,
  localparam int IdxW = $clog2(NumReq),
  localparam int PtrW = $clog2(OrdDepth),
  localparam int CntW = $clog2(OrdDepth + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         slv_aw_valid_i,
  output logic [NumReq-1:0]         slv_aw_ready_o,
  input  logic [NumReq*AwWidth-1:0] slv_aw_data_i,
  input  logic [NumReq-1:0]         slv_w_valid_i,
  output logic [NumReq-1:0]         slv_w_ready_o,
  input  logic [NumReq*WWidth-1:0]  slv_w_data_i,
  input  logic [NumReq-1:0]         slv_w_last_i,
  output logic                      mst_aw_valid_o,
  input  logic                      mst_aw_ready_i,
  output logic [AwWidth-1:0]        mst_aw_data_o,
  output logic                      mst_w_valid_o,
  input  logic                      mst_w_ready_i,
  output logic [WWidth-1:0]         mst_w_data_o,
  output logic                      mst_w_last_o,
  output logic [CntW-1:0]           outstanding_o,
  output logic                      busy_o
);
  logic [IdxW-1:0]    rr_ptr, gnt, head;
  logic [IdxW-1:0]    ord_mem [OrdDepth];
  logic [PtrW-1:0]    wr_ptr, rd_ptr;
  logic [CntW-1:0]    cnt;
  logic               aw_valid_q, armed, grant, non_empty, pop;
  logic [AwWidth-1:0] aw_data_q;
  // Scan downward so the requester closest to rr_ptr overrides the rest
  always_comb begin
    int j;
    gnt = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      j = (j >= NumReq) ? j - NumReq : j;
      gnt = slv_aw_valid_i[j] ? IdxW'(j) : gnt;
    end
  end
  // armed blocks grants on the first cycle after reset
  assign grant = armed && !rst_i && (!aw_valid_q || mst_aw_ready_i) &&
                 (cnt != CntW'(OrdDepth)) && (|slv_aw_valid_i);
  assign slv_aw_ready_o = grant ? (NumReq'(1) << gnt) : '0;
  assign mst_aw_valid_o = aw_valid_q && !rst_i;
  assign mst_aw_data_o  = aw_data_q;
  assign non_empty      = (cnt != '0) && !rst_i;
  assign head           = ord_mem[rd_ptr];
  assign mst_w_valid_o  = non_empty && slv_w_valid_i[head];
  assign mst_w_data_o   = non_empty ? slv_w_data_i[head*WWidth +: WWidth] : '0;
  assign mst_w_last_o   = non_empty && slv_w_last_i[head];
  assign slv_w_ready_o  = (non_empty && mst_w_ready_i) ? (NumReq'(1) << head) : '0;
  assign pop            = mst_w_valid_o && mst_w_ready_i && mst_w_last_o;
  assign outstanding_o  = cnt;
  assign busy_o         = aw_valid_q || (cnt != '0);
  always_ff @(posedge clk_i) if (grant) ord_mem[wr_ptr] <= gnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      aw_valid_q <= 1'b0;
      aw_data_q  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      armed      <= 1'b0;
    end else begin
      armed      <= 1'b1;
      aw_valid_q <= grant || (aw_valid_q && !mst_aw_ready_i);
      aw_data_q  <= grant ? slv_aw_data_i[gnt*AwWidth +: AwWidth] : aw_data_q;
      rr_ptr     <= grant ? ((gnt == IdxW'(NumReq - 1)) ? '0 : gnt + IdxW'(1)) : rr_ptr;
      wr_ptr     <= grant ? wr_ptr + PtrW'(1) : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + PtrW'(1) : rd_ptr;
      cnt        <= cnt + CntW'(grant) - CntW'(pop);
    end
  end
endmodule
